// File: rtl/alu_addsub_arbiter_pkg.sv
// Shared definitions for the add/sub unit arbiter: opcodes, FSM states and
// the opcode legality check.
package alu_ctrl_pkg;

  localparam logic [3:0] ADDPP = 4'b1000;
  localparam logic [3:0] ADDPN = 4'b1001;
  localparam logic [3:0] ADDNP = 4'b1010;
  localparam logic [3:0] ADDNN = 4'b1011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The four legal opcodes are exactly the 4'b10xx group.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_addsub_arbiter_if.sv
// Requester handshake, response bus and add/sub unit connection.
interface alu_addsub_arbiter_if #(parameter int WIDTH = 32);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][WIDTH-1:0] req_A;
  logic [1:0][WIDTH-1:0] req_B;
  logic [1:0][3:0]       req_control;
  logic [1:0]            rsp_valid;
  logic [WIDTH-1:0]      rsp_C;
  logic                  rsp_sign;
  logic                  rsp_error;
  logic                  au_start;
  logic [WIDTH-1:0]      au_A;
  logic [WIDTH-1:0]      au_B;
  logic [3:0]            au_control;
  logic                  au_finish;
  logic [WIDTH-1:0]      au_C;
  logic                  au_sign;

  modport master (
    output req_valid, req_A, req_B, req_control, au_finish, au_C, au_sign,
    input  req_ready, rsp_valid, rsp_C, rsp_sign, rsp_error,
           au_start, au_A, au_B, au_control
  );

  modport slave (
    input  req_valid, req_A, req_B, req_control, au_finish, au_C, au_sign,
    output req_ready, rsp_valid, rsp_C, rsp_sign, rsp_error,
           au_start, au_A, au_B, au_control
  );
endinterface

// File: rtl/alu_addsub_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the requester not served last wins.
module alu_rr_arb2 (
  input  logic       en,
  input  logic [1:0] valid,
  input  logic       last_served,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = last_served ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end
endmodule

// File: rtl/alu_addsub_arbiter.sv
// Shares one sign-magnitude add/sub unit between two requesters; one op in
// flight, results or errors (illegal opcode, unit timeout) routed back.
module alu_addsub_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic                 clock,
  input logic                 reset,
  alu_addsub_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d, err_q, err_d;
  logic [1:0]       grant;

  alu_rr_arb2 u_arb (
    .en          (state_q == IDLE),
    .valid       (bus.req_valid),
    .last_served (last_q),
    .grant       (grant)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sign_d  = sign_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (|grant) begin
        id_d   = grant[1];
        last_d = grant[1];
        a_d    = bus.req_A[grant[1]];
        b_d    = bus.req_B[grant[1]];
        ctrl_d = bus.req_control[grant[1]];
        c_d    = '0;
        sign_d = 1'b0;
        err_d  = 1'b0;
        // Illegal opcodes never reach the unit; they bounce straight back.
        if (is_legal_op(bus.req_control[grant[1]])) state_d = ISSUE;
        else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.au_finish) begin
          c_d     = bus.au_C;
          sign_d  = bus.au_sign;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          c_d     = '0;
          sign_d  = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  // Operands come from the latched copy so requesters may move on after accept.
  assign bus.req_ready  = grant;
  assign bus.au_start   = (state_q == ISSUE);
  assign bus.au_A       = a_q;
  assign bus.au_B       = b_q;
  assign bus.au_control = ctrl_q;
  assign bus.rsp_valid  = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_C      = (state_q == RESP) ? c_q : '0;
  assign bus.rsp_sign   = (state_q == RESP) & sign_q;
  assign bus.rsp_error  = (state_q == RESP) & err_q;
endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Randomised scoreboard bench: a reference add/sub unit plus expected grant,
// result and response-cycle predictions checked by independent monitors.
module tb_alu_addsub_arbiter;
  localparam int W  = 8;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_addsub_arbiter_if #(.WIDTH(W)) bus ();
  alu_addsub_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  typedef struct {
    int id; logic [W-1:0] c; logic s; logic e; int due;
  } exp_t;
  typedef struct {
    int acc_cyc; logic [W-1:0] a; logic [W-1:0] b; logic [3:0] op; int lat;
  } uop_t;

  exp_t sb_q[$];
  uop_t u_q[$];
  int   checks = 0, failures = 0, cyc = 0;
  int   acc_cnt[2] = '{0, 0};
  int   seen[2]    = '{0, 0};
  int   pend_L[2]  = '{1, 1};
  int   lat_tab[7] = '{1, 2, 3, 4, 8, 9, 30};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op >= 4'd8 && op <= 4'd11;
  endfunction

  // Sign-magnitude: bit1 negates A, bit0 negates B; magnitude truncated to W.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] op, output logic [W-1:0] c,
                                 output logic s);
    int sa, sb, r;
    sa = op[1] ? -int'(a) : int'(a);
    sb = op[0] ? -int'(b) : int'(b);
    r  = sa + sb;
    s  = (r < 0);
    c  = W'(r < 0 ? -r : r);
  endfunction

  function automatic logic [1:0] arb(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Accept recorder: predicts the grant and pushes expected responses.
  initial begin
    int last = 1;
    forever begin
      logic [1:0] v, g;
      int id;
      exp_t e;
      uop_t u;
      @(negedge clock); #1;
      if (reset) last = 1;
      else begin
        v = bus.req_valid;
        g = (sb_q.size() == 0) ? arb(v, last) : 2'b00;
        chk("req_ready", bus.req_ready, g);
        if (|(v & bus.req_ready)) begin
          id = bus.req_ready[1] ? 1 : 0;
          e.id = id; e.c = '0; e.s = 1'b0;
          u.acc_cyc = cyc; u.a = bus.req_A[id]; u.b = bus.req_B[id];
          u.op = bus.req_control[id]; u.lat = pend_L[id];
          if (!legal(u.op)) begin
            e.e = 1'b1; e.due = cyc + 1;
          end else if (u.lat <= TO) begin
            ref_op(u.a, u.b, u.op, e.c, e.s);
            e.e = 1'b0; e.due = cyc + u.lat + 2;
            u_q.push_back(u);
          end else begin
            e.e = 1'b1; e.due = cyc + 2 + TO;
            u_q.push_back(u);
          end
          sb_q.push_back(e);
          last = id;
          acc_cnt[id]++;
        end
      end
    end
  end

  // Add/sub unit model; finish lands `lat` cycles after the start cycle.
  initial begin
    int rem;
    uop_t cur;
    logic [W-1:0] rc;
    logic rs;
    rem = 0; rc = '0; rs = 1'b0;
    cur = '{0, '0, '0, 4'd0, 0};
    bus.au_finish = 1'b0; bus.au_C = '0; bus.au_sign = 1'b0;
    forever begin
      @(negedge clock);
      bus.au_finish = 1'b0;
      bus.au_C      = W'($urandom);
      bus.au_sign   = 1'($urandom);
      if (reset) begin
        rem = 0;
        u_q.delete();
      end else begin
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            bus.au_finish = 1'b1; bus.au_C = rc; bus.au_sign = rs;
            if (cur.lat <= TO) begin
              chk("au_A_stable", bus.au_A, cur.a);
              chk("au_B_stable", bus.au_B, cur.b);
            end
          end
        end
        if (bus.au_start) begin
          if (u_q.size() == 0) chk("au_start_unexpected", 1, 0);
          else begin
            cur = u_q.pop_front();
            chk("au_start_cycle", cyc, cur.acc_cyc + 1);
            chk("au_A", bus.au_A, cur.a);
            chk("au_B", bus.au_B, cur.b);
            chk("au_control", bus.au_control, cur.op);
            ref_op(cur.a, cur.b, cur.op, rc, rs);
            rem = cur.lat;
          end
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock); #2;
      if (reset) sb_q.delete();
      else if (bus.rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          e = sb_q.pop_front();
          chk("rsp_valid", bus.rsp_valid, 2'b01 << e.id);
          chk("rsp_C", bus.rsp_C, e.c);
          chk("rsp_sign", bus.rsp_sign, e.s);
          chk("rsp_error", bus.rsp_error, e.e);
          chk("rsp_cycle", cyc, e.due);
        end
      end
    end
  end

  function automatic logic [3:0] rand_op(input int pct_legal);
    logic [3:0] op;
    op = 4'($urandom_range(15));
    if ($urandom_range(99) < pct_legal) op = {2'b10, op[1:0]};
    else if (legal(op)) op = op ^ 4'b0100;
    return op;
  endfunction

  task automatic issue(input int id, input int a, input int b, input logic [3:0] op, input int lat);
    @(posedge clock); #1;
    bus.req_valid[id] = 1'b1; bus.req_A[id] = W'(a); bus.req_B[id] = W'(b);
    bus.req_control[id] = op; pend_L[id] = lat;
    for (int n = 0; n < 200 && acc_cnt[id] == seen[id]; n++) begin
      @(posedge clock); #1;
    end
    chk("accept_wait", acc_cnt[id] != seen[id], 1);
    seen[id] = acc_cnt[id];
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) if (acc_cnt[i] != seen[i]) begin
        seen[i] = acc_cnt[i];
        bus.req_valid[i] = 1'b0;
      end
      if (bus.req_valid == 2'b00 && sb_q.size() == 0) break;
      @(posedge clock); #1;
    end
    chk("drain", n < 400, 1);
  endtask

  task automatic rand_phase(input int ncyc, input int pv, input int pct_legal, input bit fast);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clock); #1;
      for (int i = 0; i < 2; i++) if (acc_cnt[i] != seen[i] || !bus.req_valid[i]) begin
        seen[i] = acc_cnt[i];
        bus.req_A[i] = W'($urandom);
        bus.req_B[i] = W'($urandom);
        if ($urandom_range(99) < pv) begin
          bus.req_valid[i]   = 1'b1;
          bus.req_control[i] = rand_op(pct_legal);
          pend_L[i] = fast ? 1 : lat_tab[$urandom_range(6)];
        end else begin
          bus.req_valid[i]   = 1'b0;
          bus.req_control[i] = 4'($urandom);
        end
      end
    end
    drain();
  endtask

  initial begin
    int n;
    bus.req_valid = 2'b00; bus.req_A = '0; bus.req_B = '0; bus.req_control = '0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_C", bus.rsp_C, 0);
    chk("rst_rsp_sign", bus.rsp_sign, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_au_start", bus.au_start, 0);
    chk("rst_au_A", bus.au_A, 0);
    chk("rst_au_B", bus.au_B, 0);
    chk("rst_au_control", bus.au_control, 0);
    @(posedge clock); #1; reset = 1'b0;
    repeat (2) @(posedge clock);

    issue(0, 5, 3, 4'b1001, 3);          // 5 - 3 = +2
    drain();
    issue(1, 9, 4, 4'b0011, 1);          // illegal opcode
    drain();
    issue(0, 20, 7, 4'b1000, 100);       // unit never answers in time
    drain();
    issue(1, 3, 10, 4'b1001, 2);         // 3 - 10 = -7
    drain();
    issue(0, 1, 1, 4'b1011, TO);         // finish on the last WAIT cycle
    drain();

    rand_phase(40, 100, 100, 1'b1);      // both always valid: strict alternation
    rand_phase(600, 60, 80, 1'b0);

    // Reset two cycles after au_start, mid-WAIT.
    issue(0, 7, 2, 4'b1000, 50);
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b1; #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_au_start", bus.au_start, 0);
    chk("arst_au_A", bus.au_A, 0);
    chk("arst_au_B", bus.au_B, 0);
    chk("arst_au_control", bus.au_control, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    chk("arst_rsp_C", bus.rsp_C, 0);
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    bus.req_A = {W'(8'd4), W'(8'd6)}; bus.req_B = {W'(8'd1), W'(8'd2)};
    bus.req_control = {4'b1000, 4'b1010};
    pend_L[0] = 2; pend_L[1] = 2;
    bus.req_valid = 2'b11;
    for (n = 0; n < 50 && acc_cnt[0] == seen[0] && acc_cnt[1] == seen[1]; n++) begin
      @(posedge clock); #1;
    end
    chk("tie_after_reset_req0", acc_cnt[0] != seen[0] && acc_cnt[1] == seen[1], 1);
    drain();
    repeat (40) @(posedge clock);        // quiet period: nothing stray may appear
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_addsub_arbiter.md
# alu_addsub_arbiter

Shares the single sign-magnitude add/sub unit between two requesters (e.g. the decode/execute path and the multiply/divide sequencer). Accepts one operation at a time through a valid/ready handshake with round-robin arbitration. Drives the unit's start/operand/control inputs and waits for its finish pulse. Returns the result to the granted requester, flagging illegal opcodes and unit timeouts as errors.

## Interface
- WIDTH, 32, operand/result width (magnitude bits)
- TIMEOUT, 64, max cycles in WAIT before aborting with error (≥ 4)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  2  per-requester operation request (bit i = requester i)
- req_ready  out  2  per-requester accept; transfer when valid & ready same cycle
- req_A, req_B  in  2×WIDTH  operand magnitudes per requester
- req_control  in  2×4  opcode per requester
- rsp_valid  out  2  one-cycle result strobe to requester i
- rsp_C  out  WIDTH  result magnitude (shared bus, qualified by rsp_valid)
- rsp_sign  out  1  result sign (1 = negative)
- rsp_error  out  1  1 = illegal opcode or timeout; rsp_C = 0, rsp_sign = 0
- au_start  out  1  start pulse to add/sub unit
- au_A, au_B  out  WIDTH  operands to unit
- au_control  out  4  opcode to unit
- au_finish  in  1  unit completion
- au_C  in  WIDTH, au_sign  in  1  unit result, valid while au_finish = 1

## Operation
- Legal opcodes: ADDPP 4'b1000, ADDPN 4'b1001, ADDNP 4'b1010, ADDNN 4'b1011. Any other value is illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = grant vector (combinational). Both valid → grant requester ≠ last_served; one valid → grant it. On accept, latch A, B, control and the requester id; last_served ← id.
  - Legal opcode → ISSUE.
  - Illegal opcode → RESP with error = 1; the unit is not started.
- ISSUE: au_start = 1 for exactly this cycle; clear the timeout counter; → WAIT.
- WAIT: au_start = 0.
  - au_finish = 1 → capture au_C and au_sign, error = 0, → RESP.
  - Otherwise increment the counter. Counter reaches TIMEOUT−1 without finish → error = 1, → RESP.
- RESP: rsp_valid[id] = 1 with the captured rsp_C/sign/error for one cycle; → IDLE.
- req_ready = 0 in every state except IDLE. Requests not accepted must be held by the requester.
- au_A, au_B, au_control are driven from the latched registers and stay stable from ISSUE until leaving WAIT. The unit requires start low before finish is sampled, which this sequencing guarantees.
- au_finish outside WAIT is ignored.
- Reset (any state, including mid-WAIT): state = IDLE, last_served = 1 (requester 0 wins the first tie), counter = 0, latched data = 0. Any in-flight operation is dropped with no response.

## Timing
- Reset values: req_ready = 2'b00 until the first request (the grant depends on valid), rsp_valid = 0, rsp_C = 0, rsp_sign = 0, rsp_error = 0, au_start = 0, au_A = au_B = 0, au_control = 0.
- Accept at cycle t, au_start at t+1, WAIT from t+2.
- au_finish seen at cycle f (f ≥ t+2) → rsp_valid at f+1. Next accept is possible at f+2.
- Illegal opcode: accept at t → rsp_valid (error) at t+1.
- Timeout: rsp_valid (error) at t+2+TIMEOUT.
- Minimum accept-to-accept spacing: 4 cycles for a legal op with 1-cycle unit latency.

## Structure
- Package alu_ctrl_pkg holds:
  - opcode localparams ADDPP/ADDPN/ADDNP/ADDNN,
  - the state enum (IDLE, ISSUE, WAIT, RESP),
  - an is_legal_op function.
- Sub-module alu_rr_arb2: two-input round-robin arbiter. Inputs are the valid vector, last_served and an enable (state==IDLE); output is a one-hot grant.
- The top level holds the FSM, operand/result registers and the timeout counter.

## Test plan
- Single legal op: req0 A=5, B=3, control=ADDPN; unit model gives au_C=2, au_sign=0 after 3 cycles.
  → au_start high one cycle at t+1; rsp_valid[0] one cycle with C=2, sign=0, error=0.
- Round robin: both valid continuously, 4 ops each.
  → grant order 0,1,0,1,… from reset; no requester served twice while the other waits.
- Illegal opcode: req1 control=4'b0011.
  → au_start never asserts; rsp_valid[1] at t+1 with error=1, C=0.
- Timeout: unit model never finishes, TIMEOUT=8.
  → rsp_valid (error=1) exactly at t+10; next request accepted normally.
- Reset mid-WAIT: assert reset 2 cycles after au_start.
  → all outputs at reset values immediately (async); no rsp_valid; after release, requester 0 wins a tie.
- Back-pressure: req0 held valid while busy, A/B changed by the bench after accept.
  → au_A/au_B keep the accepted values through WAIT; req_ready = 0 until IDLE.
